// File: rtl/gf_seq_pkg.sv
// Shared types and constants for the bit-serial GF(2^8) multiply sequencer.
package gf_seq_pkg;

    localparam int         DATA_WIDTH = 8;
    localparam logic [7:0] GF_POLY    = 8'h1B;

    // Plane read order: the MSB plane first so the multiplier can preload the reduction term.
    localparam logic [2:0] PLANE_ORDER [8] = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/gf_seq_delay.sv
// Aligns each row-read issue with its returning data: a DEPTH-deep shift
// register of {valid, step index}.
module gf_seq_delay #(
    parameter int DEPTH = 1
) (
    input  logic       sys_clk_in,
    input  logic       sys_reset_in,
    input  logic       valid_in,
    input  logic [2:0] step_in,
    output logic       valid_out,
    output logic [2:0] step_out
);

    logic [3:0] pipe_q [DEPTH];

    always_ff @(posedge sys_clk_in) begin
        // NOTE: this small array is reset on purpose; a stale valid bit after an
        // aborted command would otherwise fire phantom multiplier steps and writes.
        if (sys_reset_in) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {valid_in, step_in};
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign valid_out = pipe_q[DEPTH-1][3];
    assign step_out  = pipe_q[DEPTH-1][2:0];

endmodule

// File: rtl/gf_mult_sequencer.sv
// Runs one bit-serial GF(2^8) x2 / x3 multiply: issues plane reads, steers the
// serial multiplier, forms the x3 correction and writes back 8 product planes.
module gf_mult_sequencer
    import gf_seq_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  sys_clk_in,
    input  logic                  sys_reset_in,
    input  logic                  start_in,
    input  logic                  factor_sel_in,
    input  logic [ADDR_WIDTH-1:0] src_base_in,
    input  logic [ADDR_WIDTH-1:0] dst_base_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  rd_en_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    input  logic [DATA_WIDTH-1:0] bitline_in,
    output logic                  mult_set_msb_out,
    output logic                  mult_update_out,
    output logic                  mult_factor_sel_out,
    input  logic [DATA_WIDTH-1:0] mult_product_in,
    output logic                  wr_en_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic [DATA_WIDTH-1:0] wr_data_out
);

    state_t                  state_q, state_d;
    logic [2:0]              issue_cnt_q;
    logic [ADDR_WIDTH-1:0]   src_base_q, dst_base_q;
    logic                    factor_q;
    logic                    step_valid;
    logic [2:0]              step_idx;
    logic [DATA_WIDTH-1:0]   a7_q, hold_q;
    logic                    flush_q, wr_last_q;

    always_ff @(posedge sys_clk_in) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (sys_reset_in) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            src_base_q  <= '0;
            dst_base_q  <= '0;
            factor_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= (state_q == ISSUE) ? issue_cnt_q + 3'd1 : 3'd0;
            if (state_q == IDLE && start_in) begin
                src_base_q <= src_base_in;
                dst_base_q <= dst_base_in;
                factor_q   <= factor_sel_in;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d     = state_q;
        busy_out    = 1'b0;
        done_out    = 1'b0;
        rd_en_out   = 1'b0;
        rd_addr_out = '0;
        case (state_q)
            IDLE: if (start_in) state_d = ISSUE;
            ISSUE: begin
                busy_out    = 1'b1;
                rd_en_out   = 1'b1;
                rd_addr_out = src_base_q + ADDR_WIDTH'(PLANE_ORDER[issue_cnt_q]);
                if (issue_cnt_q == 3'd7) state_d = DRAIN;
            end
            DRAIN: begin
                busy_out = 1'b1;
                if (wr_en_out && wr_last_q) state_d = DONE;
            end
            DONE: begin
                busy_out = 1'b1;
                done_out = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    gf_seq_delay #(.DEPTH(READ_LATENCY)) u_delay (
        .sys_clk_in   (sys_clk_in),
        .sys_reset_in (sys_reset_in),
        .valid_in     (rd_en_out),
        .step_in      (issue_cnt_q),
        .valid_out    (step_valid),
        .step_out     (step_idx)
    );

    assign mult_set_msb_out    = step_valid && (step_idx == 3'd0);
    assign mult_update_out     = step_valid && (step_idx != 3'd0);
    assign mult_factor_sel_out = factor_q;

    // x3 lags x2 by one step: plane k-1 of a arrives with step k, plane 7 is kept for the flush.
    always_ff @(posedge sys_clk_in) begin
        if (sys_reset_in) begin
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
            wr_last_q   <= 1'b0;
            flush_q     <= 1'b0;
            a7_q        <= '0;
            hold_q      <= '0;
        end else begin
            wr_en_out <= 1'b0;
            wr_last_q <= 1'b0;
            flush_q   <= 1'b0;
            if (step_valid) begin
                if (!factor_q) begin
                    wr_en_out   <= 1'b1;
                    wr_addr_out <= dst_base_q + ADDR_WIDTH'(step_idx);
                    wr_data_out <= mult_product_in;
                    wr_last_q   <= (step_idx == 3'd7);
                end else if (step_idx == 3'd0) begin
                    a7_q   <= bitline_in;
                    hold_q <= mult_product_in;
                end else begin
                    wr_en_out   <= 1'b1;
                    wr_addr_out <= dst_base_q + ADDR_WIDTH'(step_idx - 3'd1);
                    wr_data_out <= hold_q ^ bitline_in;
                    hold_q      <= mult_product_in;
                    flush_q     <= (step_idx == 3'd7);
                end
            end else if (flush_q) begin
                wr_en_out   <= 1'b1;
                wr_addr_out <= dst_base_q + ADDR_WIDTH'(3'd7);
                wr_data_out <= hold_q ^ a7_q;
                wr_last_q   <= 1'b1;
            end
        end
    end

endmodule
